store_control: RTL and testbench
================================

Name: store_control

Overview:
- Write-direction counterpart of the register write-back path: takes a register value (rt) and a byte address and writes it into data memory for sw, sh and sb.
- Partial stores (sh, sb) use a read-modify-write sequence against the word-wide memory.
- Sits between the register file / ALU address output and the memory port; driven by the main control FSM with a start/done handshake.
- Misaligned stores raise an exception flag for the exception controller.

Parameters:
- RD_LAT, 1, memory read latency in cycles (range 1..4): mem_rdata is valid RD_LAT cycles after mem_addr is presented with mem_wr=0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- store_type  in  2  00=sw, 01=sh, 10=sb, 11=reserved (executed as sw).
- addr  in  32  byte address of the store.
- reg_data  in  32  rt value; sh uses [15:0], sb uses [7:0].
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
- mem_wdata  out  32  registered write data.
- mem_wr  out  1  memory write enable, high exactly one cycle per store.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misalign_excp  out  1  one-cycle pulse for a misaligned address; no memory write occurs.

Behaviour:
- Reset (async, any state): state=IDLE; mem_addr=0; mem_wdata=0; mem_wr=0; busy=0; done=0; misalign_excp=0; read counter=0. An in-flight write is abandoned and mem_wr drops immediately.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE, start=1 at edge T: latch addr, reg_data and store_type into *_q. Then:
  - misaligned (sh with addr[0]=1, or sw/11 with addr[1:0]!=0): go to EXCP;
  - sw/11: go to WRITE with mem_wdata=reg_data;
  - sh/sb: go to READ with counter=0.
- READ: mem_wr=0, mem_addr valid.
  - Counter increments each cycle.
  - When counter==RD_LAT-1, the next edge captures the merged word into mem_wdata and goes to WRITE.
  - Merge is little-endian:
    - sb: byte lane addr_q[1:0] (lane 0 = bits 7:0) is replaced by reg_data_q[7:0].
    - sh: addr_q[1]=0 replaces bits 15:0; addr_q[1]=1 replaces bits 31:16 with reg_data_q[15:0].
    - All other bits come from mem_rdata.
- WRITE: mem_wr=1 for exactly one cycle; mem_addr and mem_wdata stable; go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- EXCP: misalign_excp=1 for one cycle, done stays 0, mem_wr stays 0; then go to IDLE.
- Latency from the start edge:
  - sw: mem_wr in cycle 1, done in cycle 2.
  - sh/sb: mem_wr in cycle RD_LAT+1, done in cycle RD_LAT+2.
  - misaligned: misalign_excp in cycle 1.
- start while busy is ignored with no queuing. start is accepted again in the cycle after done or misalign_excp.
- Changes on addr, reg_data or store_type after the start edge have no effect.
- mem_addr holds its last value in IDLE.

Decomposition:
- Shared package:
  - store_type encodings ST_SW=2'b00, ST_SH=2'b01, ST_SB=2'b10, ST_RSV=2'b11;
  - state encodings IDLE, READ, WRITE, DONE, EXCP;
  - the lane-select constants.
- One sub-module, store_merge: purely combinational; inputs mem_rdata, reg_data_q, store_type_q, addr_q[1:0]; output merged word. Reusable by the load-side extractor's bench as a reference model.

Test Plan:
- sw, addr=0x0000_0010, reg_data=0xDEAD_BEEF -> cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF; cycle 2: done=1; no read cycles.
- sb, addr=0x0000_0013, reg_data=0x1234_56AB, mem_rdata=0x1122_3344, RD_LAT=1 -> mem_wr in cycle 2, mem_wdata=0xAB22_3344, mem_addr=0x10; done in cycle 3.
- sh, addr=0x0000_0006, reg_data=0x0000_CAFE, mem_rdata=0xAAAA_BBBB, RD_LAT=3 -> mem_wr in cycle 4, mem_wdata=0xCAFE_BBBB, mem_addr=0x4.
- sh at addr=0x0000_0005 and sw at addr=0x0000_0002 -> misalign_excp pulse in cycle 1; mem_wr and done never asserted; busy back to 0 in cycle 2.
- start re-asserted during READ, and addr changed mid-operation -> ignored; the write uses the originally latched address and data.
- reset asserted asynchronously during WRITE -> mem_wr, busy and done go to 0 immediately; after release, a new sw completes normally.

Source files
------------

// File: rtl/store_control_pkg.sv
// rtl/store_control_pkg.sv - shared encodings and helpers for the store path
package store_control_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_type_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    EXCP
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;
  localparam logic       HALF_HI = 1'b1;

  // Bytes are always aligned; reserved encoding is treated as a word store.
  function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] lo);
    logic mis;
    case (st)
      ST_SH:   mis = lo[0];
      ST_SB:   mis = 1'b0;
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - little-endian byte/half merge of store data into a memory word
module store_merge
  import store_control_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [31:0] reg_data_q,
  input  logic [1:0]  store_type_q,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = mem_rdata;
    case (store_type_q)
      ST_SB: begin
        case (addr_lo)
          LANE0: merged[7:0]   = reg_data_q[7:0];
          LANE1: merged[15:8]  = reg_data_q[7:0];
          LANE2: merged[23:16] = reg_data_q[7:0];
          LANE3: merged[31:24] = reg_data_q[7:0];
          default: merged = mem_rdata;
        endcase
      end
      ST_SH: begin
        if (addr_lo[1] == HALF_HI) merged[31:16] = reg_data_q[15:0];
        else                       merged[15:0]  = reg_data_q[15:0];
      end
      default: merged = reg_data_q;
    endcase
  end

endmodule

// File: rtl/store_control.sv
// rtl/store_control.sv - sw/sh/sb store sequencer with read-modify-write for partial stores
module store_control
  import store_control_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign_excp
);

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] reg_data_q;
  logic [1:0]  store_type_q;
  logic [1:0]  rd_cnt;
  logic [31:0] merged;

  store_merge u_merge (
    .mem_rdata    (mem_rdata),
    .reg_data_q   (reg_data_q),
    .store_type_q (store_type_q),
    .addr_lo      (addr_q[1:0]),
    .merged       (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      reg_data_q   <= '0;
      store_type_q <= ST_SW;
      mem_wdata    <= '0;
      rd_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q       <= addr;
            reg_data_q   <= reg_data;
            store_type_q <= store_type;
            rd_cnt       <= '0;
            if (is_misaligned(store_type, addr[1:0])) begin
              state <= EXCP;
            end else if (store_type == ST_SH || store_type == ST_SB) begin
              state <= READ;
            end else begin
              mem_wdata <= reg_data;
              state     <= WRITE;
            end
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 2'd1;
          // mem_rdata is valid at the edge that ends the last wait cycle
          if (rd_cnt == LAST_CNT) begin
            mem_wdata <= merged;
            state     <= WRITE;
          end
        end
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        EXCP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wr        = (state == WRITE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign misalign_excp = (state == EXCP);

endmodule

// File: tb/tb_store_control.sv
// tb/tb_store_control.sv - scoreboard bench for store_control at read latencies 1 and 3
module tb_store_control;
  import store_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] reg_data = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ma1, wd1, ma3, wd3;
  logic        wr1, busy1, done1, ex1;
  logic        wr3, busy3, done3, ex3;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wr_k;
    int          done_k;
    bit          excp;
    int          base;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  bit   wr_seen1 = 0;
  bit   wr_seen3 = 0;

  store_control #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type), .addr(addr),
    .reg_data(reg_data), .mem_rdata(mem_rdata), .mem_addr(ma1), .mem_wdata(wd1),
    .mem_wr(wr1), .busy(busy1), .done(done1), .misalign_excp(ex1)
  );

  store_control #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type), .addr(addr),
    .reg_data(reg_data), .mem_rdata(mem_rdata), .mem_addr(ma3), .mem_wdata(wd3),
    .mem_wr(wr3), .busy(busy3), .done(done3), .misalign_excp(ex3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input logic [1:0] t, input logic [31:0] a,
                                           input logic [31:0] d, input logic [31:0] r);
    logic [31:0] m;
    logic [31:0] v;
    int          sh;
    if (t == ST_SB) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'h0000_00FF << sh;
      v  = {4{d[7:0]}};
    end else if (t == ST_SH) begin
      sh = 16 * int'(a[1]);
      m  = 32'h0000_FFFF << sh;
      v  = {2{d[15:0]}};
    end else begin
      m = '1;
      v = d;
    end
    return (r & ~m) | (v & m);
  endfunction

  always @(negedge clk) begin : mon1
    exp_t e;
    int   k;
    if (!reset) begin
      if (wr1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL wr1_unexpected got mem_wr=1 required no write");
        end else begin
          e = q1[0];
          k = cyc - e.base;
          total++; if (ma1 !== e.addr) begin bad++; $display("FAIL wr1_addr got %h required %h", ma1, e.addr); end
          total++; if (wd1 !== e.data) begin bad++; $display("FAIL wr1_data got %h required %h", wd1, e.data); end
          total++; if (k !== e.wr_k) begin bad++; $display("FAIL wr1_cycle got %0d required %0d", k, e.wr_k); end
          total++; if (wr_seen1) begin bad++; $display("FAIL wr1_double got 2 writes required 1"); end
          wr_seen1 = 1;
        end
      end
      if (done1 || ex1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL end1_unexpected got done=%b excp=%b required none", done1, ex1);
        end else begin
          e = q1.pop_front();
          k = cyc - e.base;
          if (done1) begin
            total++; if (k !== e.done_k) begin bad++; $display("FAIL done1_cycle got %0d required %0d", k, e.done_k); end
            total++; if (!wr_seen1) begin bad++; $display("FAIL done1_nowrite got 0 writes required 1"); end
          end else begin
            total++; if (!e.excp || k !== 1) begin bad++; $display("FAIL excp1 got cycle %0d required excp=%b at cycle 1", k, e.excp); end
            total++; if (wr_seen1) begin bad++; $display("FAIL excp1_write got a write required none"); end
          end
          wr_seen1 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    int   k;
    if (!reset) begin
      if (wr3) begin
        if (q3.size() == 0) begin
          total++; bad++;
          $display("FAIL wr3_unexpected got mem_wr=1 required no write");
        end else begin
          e = q3[0];
          k = cyc - e.base;
          total++; if (ma3 !== e.addr) begin bad++; $display("FAIL wr3_addr got %h required %h", ma3, e.addr); end
          total++; if (wd3 !== e.data) begin bad++; $display("FAIL wr3_data got %h required %h", wd3, e.data); end
          total++; if (k !== e.wr_k) begin bad++; $display("FAIL wr3_cycle got %0d required %0d", k, e.wr_k); end
          total++; if (wr_seen3) begin bad++; $display("FAIL wr3_double got 2 writes required 1"); end
          wr_seen3 = 1;
        end
      end
      if (done3 || ex3) begin
        if (q3.size() == 0) begin
          total++; bad++;
          $display("FAIL end3_unexpected got done=%b excp=%b required none", done3, ex3);
        end else begin
          e = q3.pop_front();
          k = cyc - e.base;
          if (done3) begin
            total++; if (k !== e.done_k) begin bad++; $display("FAIL done3_cycle got %0d required %0d", k, e.done_k); end
            total++; if (!wr_seen3) begin bad++; $display("FAIL done3_nowrite got 0 writes required 1"); end
          end else begin
            total++; if (!e.excp || k !== 1) begin bad++; $display("FAIL excp3 got cycle %0d required excp=%b at cycle 1", k, e.excp); end
            total++; if (wr_seen3) begin bad++; $display("FAIL excp3_write got a write required none"); end
          end
          wr_seen3 = 0;
        end
      end
    end
  end

  // Drives a one-cycle start and records what each latency variant should produce.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r);
    exp_t e;
    bit   mis;
    bit   partial;
    @(negedge clk);
    store_type = t; addr = a; reg_data = d; mem_rdata = r; start = 1'b1;
    mis     = (t == ST_SH) ? a[0] : (t == ST_SB) ? 1'b0 : (a[1:0] != 2'b00);
    partial = (t == ST_SH) || (t == ST_SB);
    e.addr   = {a[31:2], 2'b00};
    e.data   = exp_word(t, a, d, r);
    e.excp   = mis;
    e.base   = cyc;
    e.wr_k   = mis ? -1 : (partial ? 2 : 1);
    e.done_k = mis ? -1 : e.wr_k + 1;
    q1.push_back(e);
    e.wr_k   = mis ? -1 : (partial ? 4 : 1);
    e.done_k = mis ? -1 : e.wr_k + 1;
    q3.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy1 && !busy3 && q1.size() == 0 && q3.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({ma1, wd1, wr1, busy1, done1, ex1} !== '0) begin
      bad++; $display("FAIL reset_dut1 got %h/%h/%b%b%b%b required all zero", ma1, wd1, wr1, busy1, done1, ex1);
    end
    total++;
    if ({ma3, wd3, wr3, busy3, done3, ex3} !== '0) begin
      bad++; $display("FAIL reset_dut3 got %h/%h/%b%b%b%b required all zero", ma3, wd3, wr3, busy3, done3, ex3);
    end
    reset = 1'b0;
  endtask

  task automatic test_sw();
    bit ok;
    issue(ST_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sw_timeout got busy required idle"); end
    total++; if (wd1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got %h required deadbeef", wd1); end
    issue(ST_RSV, 32'h0000_0100, 32'h0123_4567, 32'hFFFF_FFFF);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rsv_timeout got busy required idle"); end
  endtask

  task automatic test_sb();
    bit ok;
    issue(ST_SB, 32'h0000_0013, 32'h1234_56AB, 32'h1122_3344);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sb_timeout got busy required idle"); end
    total++; if (wd1 !== 32'hAB22_3344) begin bad++; $display("FAIL sb_wdata got %h required ab223344", wd1); end
    for (int l = 0; l < 4; l++) begin
      issue(ST_SB, 32'h0000_0200 + l, $urandom, $urandom);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL sb_lane%0d_timeout got busy required idle", l); end
    end
  endtask

  task automatic test_sh();
    bit ok;
    issue(ST_SH, 32'h0000_0006, 32'h0000_CAFE, 32'hAAAA_BBBB);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sh_timeout got busy required idle"); end
    total++; if (wd3 !== 32'hCAFE_BBBB) begin bad++; $display("FAIL sh_wdata got %h required cafebbbb", wd3); end
    total++; if (ma3 !== 32'h0000_0004) begin bad++; $display("FAIL sh_addr got %h required 00000004", ma3); end
    issue(ST_SH, 32'h0000_0404, 32'h7777_1234, 32'h9876_5432);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sh_lo_timeout got busy required idle"); end
  endtask

  task automatic test_misalign();
    bit ok;
    issue(ST_SH, 32'h0000_0005, 32'h0000_1111, 32'h0);
    total++; if (ex1 !== 1'b1 || ex3 !== 1'b1) begin bad++; $display("FAIL mis_sh_pulse got %b%b required 11", ex1, ex3); end
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL mis_sh_busy got %b%b required 00", busy1, busy3); end
    issue(ST_SW, 32'h0000_0002, 32'h2222_2222, 32'h0);
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL mis_sw_busy got %b%b required 00", busy1, busy3); end
    issue(ST_RSV, 32'h0000_0009, 32'h3333_3333, 32'h0);
    issue(ST_SB, 32'h0000_0007, 32'h0000_00C3, 32'h0102_0304);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL mis_timeout got busy required idle"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    issue(ST_SH, 32'h0000_0022, 32'h0000_1357, 32'h89AB_CDEF);
    start = 1'b1; store_type = ST_SW; addr = 32'h0000_0040; reg_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; addr = 32'h0000_0080; reg_data = 32'h0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got busy required idle"); end
    total++; if (ma3 !== 32'h0000_0020) begin bad++; $display("FAIL b2b_addr got %h required 00000020", ma3); end
    total++; if (wd3 !== 32'h1357_CDEF) begin bad++; $display("FAIL b2b_wdata got %h required 1357cdef", wd3); end
  endtask

  task automatic test_reset_write();
    bit ok;
    issue(ST_SW, 32'h0000_0030, 32'hA5A5_5A5A, 32'h0);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({wr1, busy1, done1, wr3, busy3, done3} !== 6'b0) begin
      bad++; $display("FAIL rst_async got %b%b%b %b%b%b required all zero", wr1, busy1, done1, wr3, busy3, done3);
    end
    q1.delete(); q3.delete();
    wr_seen1 = 0; wr_seen3 = 0;
    @(negedge clk);
    reset = 1'b0;
    issue(ST_SW, 32'h0000_0044, 32'h0BAD_F00D, 32'h0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_after_timeout got busy required idle"); end
    total++; if (wd1 !== 32'h0BAD_F00D) begin bad++; $display("FAIL rst_after_wdata got %h required 0badf00d", wd1); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misalign();
    test_back_to_back();
    test_reset_write();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required completion");
    $fatal(1);
  end

endmodule
